fnd_share_arbiter: RTL
======================

// Module: fnd_share_arbiter
// PURPOSE
//  Shares the single 4-digit FND display among N_SRC requesters (counters, clock, sensors).
//  Round-robin arbiter with a minimum on-screen hold time per source.
//  The granted source's 16-bit value (4 hex digits) is registered onto value_out.
//  value_out feeds the FND scan driver's value input.
//  The scan driver and 7-seg decoding are not part of this block.
// PARAMETERS
//  N_SRC     4               number of requesters (>=2)
//  HOLD_CYC  125_000_000     clk cycles a grant is held (1 s at 8 ns clk); >=2; sims use 8
//  IDLE_VAL  16'h0000        value_out when no source is granted
// PORTS
//  clk        in   1         system clock, all logic on posedge
//  reset_n    in   1         asynchronous, active-low reset
//  req        in   N_SRC     level request per source; bit i = source i wants display
//  src_value  in   16*N_SRC  source i value at [16*i+15:16*i], digit3 in MSBs
//  grant      out  N_SRC     one-hot current owner; all-zero when none
//  value_out  out  16        registered value to FND driver
//  busy       out  1         1 while state==SHOW
//  hold_done  out  1         1-cycle pulse when a full hold period expires
// BEHAVIOUR
//  Reset (async, reset_n=0): grant=0, value_out=IDLE_VAL, busy=0, hold_done=0.
//    Also on reset: state=IDLE, hold_cnt=0, last_ptr=N_SRC-1 (source 0 wins first).
//  hold_cnt: unsigned, width $clog2(HOLD_CYC); counts 0..HOLD_CYC-1 and never wraps past it.
//  FSM states: IDLE, SHOW, SWITCH; all outputs registered.
//  IDLE:
//    - grant=0, value_out=IDLE_VAL.
//    - Any req bit high at edge t -> SHOW at t+1.
//    - At t+1: grant = first set req bit searching last_ptr+1, +2, ... modulo N_SRC.
//    - At t+1: value_out = that source's value; last_ptr <- winner; hold_cnt <- 0.
//  SHOW:
//    - value_out <= src_value[grant] every cycle (live, 1-cycle latency).
//    - hold_cnt increments each cycle.
//    - Granted req drops before expiry: next cycle SWITCH (early release, no hold).
//    - hold_cnt==HOLD_CYC-1: hold_done=1 for that cycle; then:
//        any other req bit set   -> SWITCH;
//        else owner still req    -> stay SHOW, hold_cnt <- 0 (no gap, grant unchanged);
//        else                    -> IDLE.
//  SWITCH (exactly 1 cycle):
//    - grant=0; value_out keeps its previous value (no blank flicker).
//    - Any req set -> SHOW with next RR winner, same search rule as IDLE.
//    - No req set -> IDLE.
//  Round robin: search always starts after last_ptr.
//    Owner re-wins only if it is the sole requester.
//  Simultaneous drop of owner req and hold expiry: treated as expiry with owner not requesting.
//  Reqs arriving mid-hold never preempt; they wait for expiry or owner release.
//  Async reset mid-SHOW: outputs clear immediately, without waiting for a clock edge.
// TESTING (HOLD_CYC=8, N_SRC=4, IDLE_VAL=16'h0000)
//  1. reset_n=0 mid-run, no clk edge -> grant=0000, value_out=0000, busy=0 at once.
//     After release with req=0001 -> grant=0001 next edge.
//  2. req=0100, src2=16'h1234 held -> grant=0100, value_out=1234 one edge later.
//     hold_done pulses every 8 cycles; grant never drops.
//  3. req=1111, distinct values -> grant sequence 0001,0010,0100,1000,0001.
//     Each grant lasts 8 cycles, followed by 1 cycle grant=0000 with value_out held.
//  4. src0 granted, req[0] falls at hold_cnt=3, req[1]=1 -> next cycle SWITCH.
//     Following cycle grant=0010; hold_done never pulses for src0.
//  5. src1 granted, src1 value 0x0042->0x0043 mid-hold -> value_out=0043 one edge later.
//  6. All req drop during SHOW -> SWITCH then IDLE.
//     Then value_out=0000; later req=1000 -> grant=1000 (RR resumes after last_ptr).

Source files
------------

// File: rtl/fnd_share_arbiter.sv
// Round-robin arbiter that shares one 4-digit FND display among N_SRC requesters.
// Each grant is held for HOLD_CYC cycles unless the owner releases it early.
module fnd_share_arbiter #(
  parameter int          N_SRC    = 4,
  parameter int          HOLD_CYC = 125_000_000,
  parameter logic [15:0] IDLE_VAL = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_SRC-1:0]     req,
  input  logic [16*N_SRC-1:0]  src_value,
  output logic [N_SRC-1:0]     grant,
  output logic [15:0]          value_out,
  output logic                 busy,
  output logic                 hold_done,
  output logic [1:0]           state_dbg
);

  localparam int PTR_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  hold_cnt, cnt_d;
  logic [PTR_W-1:0]  last_ptr, ptr_d;
  logic [N_SRC-1:0]  grant_d;
  logic [15:0]       value_d;
  logic              busy_d, done_d;

  logic              win_valid;
  logic [PTR_W-1:0]  win_idx;
  logic              owner_req, other_req, expired, take;

  // Handshake: req is a level request held by the source; grant is the one-hot
  // acknowledge. A source owns the display for every cycle its grant bit is high.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_SRC-1:0] r,
                                             input logic [PTR_W-1:0] last);
    logic             found;
    logic [PTR_W-1:0] pick;
    int               idx;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(last) + k) % N_SRC;
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    return {found, pick};
  endfunction

  assign {win_valid, win_idx} = rr_pick(req, last_ptr);
  assign owner_req = req[last_ptr];
  assign other_req = |(req & ~(N_SRC'(1) << last_ptr));
  assign expired   = (hold_cnt == CNT_MAX);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_ptr  <= PTR_W'(N_SRC - 1);
      grant     <= '0;
      value_out <= IDLE_VAL;
      busy      <= 1'b0;
      hold_done <= 1'b0;
    end else begin
      state     <= next_state;
      hold_cnt  <= cnt_d;
      last_ptr  <= ptr_d;
      grant     <= grant_d;
      value_out <= value_d;
      busy      <= busy_d;
      hold_done <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    cnt_d      = '0;
    ptr_d      = last_ptr;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          next_state = SHOW;
          take       = 1'b1;
        end
      end
      SHOW: begin
        // Expiry wins over a simultaneous owner drop; a sole owner keeps the display gap-free.
        if (expired) begin
          if (other_req)      next_state = SWITCH;
          else if (owner_req) next_state = SHOW;
          else                next_state = IDLE;
        end else if (!owner_req) begin
          next_state = SWITCH;
        end else begin
          cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      SWITCH: begin
        if (win_valid) begin
          next_state = SHOW;
          take       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (take) ptr_d = win_idx;
  end

  always_comb begin
    grant_d = '0;
    value_d = value_out;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (next_state)
      SHOW: begin
        grant_d = N_SRC'(1) << ptr_d;
        value_d = src_value[int'(ptr_d)*16 +: 16];
        busy_d  = 1'b1;
        done_d  = (cnt_d == CNT_MAX);
      end
      IDLE:    value_d = IDLE_VAL;
      default: value_d = value_out;
    endcase
  end

endmodule
